spi_aes_frame_ctrl: RTL and testbench

Command/frame controller between the byte-level SPI slave and the AES-128 core. It parses SPI byte streams into commands and assembles 16-byte key and plaintext blocks. It starts the AES core, captures the ciphertext, and serves result bytes and a status byte back to the SPI slave's transmit input. Bytes are sequenced per SPI frame; a frame is the interval during which slave select is low.

---
 rtl/spi_aes_frame_ctrl.sv | 241 ++++++++++++++++++++++++
 tb/tb_spi_aes_frame_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_aes_frame_ctrl.sv
// Frame/command controller between a byte-level SPI slave and an AES-128 core.
// Assembles key and plaintext blocks, runs the core and serves result and status bytes.
module spi_aes_frame_ctrl #(
    parameter int BLOCK_BYTES = 16,
    parameter int TIMEOUT     = 1023
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ss,
    input  logic                     rx_valid,
    input  logic [7:0]               rx_byte,
    output logic [7:0]               tx_byte,
    output logic [8*BLOCK_BYTES-1:0] aes_key,
    output logic [8*BLOCK_BYTES-1:0] aes_din,
    output logic                     aes_start,
    input  logic                     aes_done,
    input  logic [8*BLOCK_BYTES-1:0] aes_dout,
    output logic                     busy,
    output logic                     err
);

    localparam int BW = 8 * BLOCK_BYTES;
    localparam int CW = (BLOCK_BYTES > 1) ? $clog2(BLOCK_BYTES) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [CW-1:0] LAST     = CW'(BLOCK_BYTES - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    localparam logic [7:0] CMD_LOAD_KEY = 8'h01;
    localparam logic [7:0] CMD_ENCRYPT  = 8'h02;
    localparam logic [7:0] CMD_READ     = 8'h03;
    localparam logic [7:0] CMD_STATUS   = 8'h04;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        RX_KEY,
        RX_DATA,
        START,
        WAIT,
        READ,
        DRAIN
    } state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [TW-1:0]   tmo, tmo_n;
    logic [BW-1:0]   key_n, din_n, res, res_n;
    logic [7:0]      tx_n;
    logic            start_n, busy_n, err_n;
    logic            key_valid, key_valid_n;
    logic            res_valid, res_valid_n;
    logic            read_done, read_done_n;
    logic            ss_q;
    logic [CW-1:0]   slot, slot_n;

    // Byte slot 0 of a block sits in the top byte (MSB-first transfer).
    assign slot = LAST - cnt;

    always_comb begin
        // NOTE: every variable gets a default before the case so no path can infer a latch.
        state_n     = state;
        cnt_n       = cnt;
        tmo_n       = '0;
        key_n       = aes_key;
        din_n       = aes_din;
        res_n       = res;
        start_n     = 1'b0;
        busy_n      = busy;
        err_n       = err;
        key_valid_n = key_valid;
        res_valid_n = res_valid;
        read_done_n = read_done;
        slot_n      = '0;
        tx_n        = 8'h00;

        case (state)
            IDLE: begin
                if (ss_q && !ss) begin
                    state_n = CMD;
                    cnt_n   = '0;
                end
            end
            CMD: begin
                if (rx_valid) begin
                    cnt_n = '0;
                    case (rx_byte)
                        CMD_LOAD_KEY: begin
                            state_n     = RX_KEY;
                            key_valid_n = 1'b0;
                        end
                        CMD_ENCRYPT: begin
                            if (!busy && key_valid) begin
                                state_n = RX_DATA;
                            end else begin
                                err_n   = 1'b1;
                                state_n = DRAIN;
                            end
                        end
                        CMD_READ: begin
                            if (res_valid) begin
                                state_n = READ;
                            end else begin
                                err_n   = 1'b1;
                                state_n = DRAIN;
                            end
                        end
                        CMD_STATUS: begin
                            err_n   = 1'b0;
                            state_n = DRAIN;
                        end
                        default: begin
                            err_n   = 1'b1;
                            state_n = DRAIN;
                        end
                    endcase
                end
            end
            RX_KEY: begin
                if (rx_valid) begin
                    key_n[{slot, 3'b000} +: 8] = rx_byte;
                    key_valid_n                = 1'b0;
                    if (cnt == LAST) begin
                        key_valid_n = 1'b1;
                        cnt_n       = '0;
                        state_n     = DRAIN;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
            end
            RX_DATA: begin
                if (rx_valid) begin
                    din_n[{slot, 3'b000} +: 8] = rx_byte;
                    if (cnt == LAST) begin
                        cnt_n   = '0;
                        state_n = START;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
            end
            START: begin
                state_n = WAIT;
            end
            WAIT: begin
                // A done pulse coinciding with the timeout compare still delivers the result.
                if (aes_done) begin
                    res_n       = aes_dout;
                    res_valid_n = 1'b1;
                    busy_n      = 1'b0;
                    state_n     = ss ? IDLE : DRAIN;
                end else if (tmo == TMO_LAST) begin
                    err_n   = 1'b1;
                    busy_n  = 1'b0;
                    state_n = IDLE;
                end else begin
                    tmo_n = tmo + 1'b1;
                end
            end
            READ: begin
                if (rx_valid) begin
                    if (cnt == LAST) begin
                        cnt_n       = '0;
                        read_done_n = 1'b1;
                        state_n     = DRAIN;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
            end
            DRAIN: begin
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase

        // The byte of this cycle has been processed above; a rising ss now ends the frame.
        if (ss && (state inside {CMD, RX_KEY, RX_DATA, READ, DRAIN})) begin
            state_n = IDLE;
            cnt_n   = '0;
        end

        if (state_n == IDLE) begin
            read_done_n = 1'b0;
        end

        if (state_n == START) begin
            start_n     = 1'b1;
            busy_n      = 1'b1;
            res_valid_n = 1'b0;
        end

        if (state_n == READ) begin
            slot_n = LAST - cnt_n;
            tx_n   = res[{slot_n, 3'b000} +: 8];
        end else if (read_done_n) begin
            tx_n = 8'h00;
        end else begin
            tx_n = {busy_n, key_valid_n, res_valid_n, err_n, 4'b0101};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            tmo       <= '0;
            aes_key   <= '0;
            aes_din   <= '0;
            res       <= '0;
            tx_byte   <= 8'h00;
            aes_start <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
            key_valid <= 1'b0;
            res_valid <= 1'b0;
            read_done <= 1'b0;
            ss_q      <= 1'b1;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            tmo       <= tmo_n;
            aes_key   <= key_n;
            aes_din   <= din_n;
            res       <= res_n;
            tx_byte   <= tx_n;
            aes_start <= start_n;
            busy      <= busy_n;
            err       <= err_n;
            key_valid <= key_valid_n;
            res_valid <= res_valid_n;
            read_done <= read_done_n;
            ss_q      <= ss;
        end
    end

endmodule

// File: tb/tb_spi_aes_frame_ctrl.sv
// Directed bench for spi_aes_frame_ctrl: key/data loading, encryption, readback, errors, timeout, abort.
module tb_spi_aes_frame_ctrl;

    localparam int BB  = 16;
    localparam int TMO = 1023;

    localparam logic [127:0] KEY = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
    localparam logic [127:0] PT  = 128'h3243f6a8_885a308d_313198a2_e0370734;
    localparam logic [127:0] CT  = 128'h3925841d_02dc09fb_dc118597_196a0b32;
    localparam logic [127:0] PT2 = 128'h10111213_14151617_18191a1b_1c1d1e1f;
    localparam logic [127:0] CT2 = 128'hdeadbeef_00112233_44556677_8899aabb;

    logic         clk = 1'b0;
    logic         rst;
    logic         ss;
    logic         rx_valid;
    logic [7:0]   rx_byte;
    logic [7:0]   tx_byte;
    logic [127:0] aes_key;
    logic [127:0] aes_din;
    logic         aes_start;
    logic         aes_done;
    logic [127:0] aes_dout;
    logic         busy;
    logic         err;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    spi_aes_frame_ctrl #(.BLOCK_BYTES(BB), .TIMEOUT(TMO)) dut (
        .clk       (clk),
        .rst       (rst),
        .ss        (ss),
        .rx_valid  (rx_valid),
        .rx_byte   (rx_byte),
        .tx_byte   (tx_byte),
        .aes_key   (aes_key),
        .aes_din   (aes_din),
        .aes_start (aes_start),
        .aes_done  (aes_done),
        .aes_dout  (aes_dout),
        .busy      (busy),
        .err       (err)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        repeat (2) @(negedge clk);
        rx_valid = 1'b1;
        rx_byte  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_block(input logic [127:0] blk);
        for (int i = 0; i < BB; i++) begin
            send_byte(blk[8*(BB-1-i) +: 8]);
        end
    endtask

    task automatic frame_begin();
        @(negedge clk);
        ss = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic frame_end();
        @(negedge clk);
        ss = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic done_pulse(input logic [127:0] ct);
        @(negedge clk);
        aes_done = 1'b1;
        aes_dout = ct;
        @(negedge clk);
        aes_done = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [127:0] exp_blk;
        logic         ok;

        rst      = 1'b1;
        ss       = 1'b1;
        rx_valid = 1'b0;
        rx_byte  = 8'h00;
        aes_done = 1'b0;
        aes_dout = '0;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_tx", tx_byte, 8'h00);
        check("rst_busy_err_start", {busy, err, aes_start}, 3'b000);
        check("rst_key", aes_key, '0);
        check("rst_din", aes_din, '0);
        rst = 1'b0;
        @(negedge clk);
        check("status_after_rst", tx_byte, 8'h05);

        // Reset in the middle of a key load
        frame_begin();
        send_byte(8'h01);
        for (int i = 0; i < 5; i++) send_byte(8'h11 + 8'(i));
        check("partial_key", aes_key, 128'h11121314_15000000_00000000_00000000);
        #2 rst = 1'b1;
        #1;
        check("async_rst_key", aes_key, '0);
        check("async_rst_tx", tx_byte, 8'h00);
        @(negedge clk);
        ss  = 1'b1;
        rst = 1'b0;
        @(negedge clk);
        check("status_after_midrst", tx_byte, 8'h05);

        // Load key, then encrypt
        frame_begin();
        send_byte(8'h01);
        send_block(KEY);
        check("key_loaded", aes_key, KEY);
        check("status_key_valid", tx_byte, 8'h45);
        frame_end();

        frame_begin();
        send_byte(8'h02);
        send_block(PT);
        check("din_loaded", aes_din, PT);
        check("start_pulse", aes_start, 1'b1);
        check("busy_at_start", busy, 1'b1);
        check("status_busy", tx_byte, 8'hc5);
        @(negedge clk);
        check("start_one_cycle", aes_start, 1'b0);
        repeat (8) @(negedge clk);
        done_pulse(CT);
        check("busy_after_done", busy, 1'b0);
        check("status_result", tx_byte, 8'h65);
        frame_end();

        // Read the result back
        frame_begin();
        send_byte(8'h03);
        exp_blk = CT;
        for (int i = 0; i < BB; i++) begin
            check($sformatf("read_byte_%0d", i), tx_byte, exp_blk[8*(BB-1-i) +: 8]);
            send_byte(8'h00);
        end
        check("read_tail_zero", tx_byte, 8'h00);
        frame_end();
        check("res_valid_kept", tx_byte, 8'h65);

        // ENCRYPT without a key, then STATUS clears err
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        frame_begin();
        send_byte(8'h02);
        check("err_no_key", err, 1'b1);
        check("status_err", tx_byte, 8'h15);
        frame_end();
        frame_begin();
        check("status_frame_first", tx_byte, 8'h15);
        send_byte(8'h04);
        check("status_cleared", tx_byte, 8'h05);
        check("err_cleared", err, 1'b0);
        frame_end();

        // Timeout with no aes_done
        frame_begin();
        send_byte(8'h01);
        send_block(KEY);
        frame_end();
        frame_begin();
        send_byte(8'h02);
        send_block(PT);
        check("tmo_start", aes_start, 1'b1);
        ok = 1'b1;
        for (int k = 1; k <= TMO; k++) begin
            @(negedge clk);
            if (!busy || err) ok = 1'b0;
        end
        check("tmo_busy_held", ok, 1'b1);
        @(negedge clk);
        check("tmo_busy_fell", busy, 1'b0);
        check("tmo_err", err, 1'b1);
        check("tmo_status", tx_byte, 8'h55);
        frame_end();

        // Abort after 7 plaintext bytes, then a full frame restarts at byte 0
        frame_begin();
        send_byte(8'h02);
        for (int i = 0; i < 7; i++) send_byte(8'ha0 + 8'(i));
        @(negedge clk);
        ss = 1'b1;
        ok = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (aes_start || busy) ok = 1'b0;
        end
        check("abort_no_start", ok, 1'b1);
        frame_begin();
        send_byte(8'h02);
        send_block(PT2);
        check("restart_din", aes_din, PT2);
        check("restart_start", aes_start, 1'b1);
        repeat (3) @(negedge clk);
        done_pulse(CT2);
        check("restart_status", tx_byte, 8'h75);
        frame_end();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
